// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps ALUOp (and funct for R-type) to the 3-bit ALU code.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);

  // Funct is only consulted, and only flagged, when ALUOp selects it.
  always_comb begin
    alu_control   = ALU_ADD;
    illegal_funct = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: illegal_funct = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore main FSM with memory-ready handshake,
// illegal opcode/funct trapping, and ALU decoder.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_JUMP  = 1'b1,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                i_or_d,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ir_write,
  output logic                mem_write,
  output logic                mem_req,
  output logic                pc_en,
  output logic                reg_write,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  state_t     state, next_state;
  alu_op_t    alu_op;
  logic [2:0] alu_ctl3;
  logic       illegal_funct;
  logic       illegal_op;
  logic       reg_write_fsm;

  mips_alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_ctl3),
    .illegal_funct (illegal_funct)
  );

  // State register; reset abandons any instruction and returns to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    next_state    = S_FETCH;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    i_or_d        = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    mem_req       = 1'b0;
    pc_en         = 1'b0;
    reg_write_fsm = 1'b0;
    alu_op        = ALUOP_ADD;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_en      = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI: begin
            if (EN_ADDI) next_state = S_ADDIEX;
            else         illegal_op = 1'b1;
          end
          OP_J: begin
            if (EN_JUMP) next_state = S_JUMP;
            else         illegal_op = 1'b1;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_fsm = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        i_or_d     = 1'b1;
        mem_write  = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        // Keep the decoder on funct so it can qualify the writeback.
        reg_dst = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: reg_write_fsm = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Funct-dependent terms kept outside the FSM block to avoid a false comb loop.
  assign reg_write   = reg_write_fsm | ((state == S_ALUWB) & ~illegal_funct);
  assign illegal     = illegal_op | ((state == S_ALUWB) & illegal_funct);
  assign alu_control = ALUCTL_W'(alu_ctl3);
  assign state_dbg   = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed self-checking bench for the multicycle MIPS control unit.
module tb_mips_mc_controller;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode, funct;

  logic       mem_to_reg, reg_dst, i_or_d, alu_src_a, ir_write, mem_write;
  logic       mem_req, pc_en, reg_write, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_control, state_dbg;

  logic       mem_to_reg2, reg_dst2, i_or_d2, alu_src_a2, ir_write2, mem_write2;
  logic       mem_req2, pc_en2, reg_write2, illegal2;
  logic [1:0] pc_src2, alu_src_b2;
  logic [2:0] alu_control2;
  logic [3:0] state_dbg2;

  int checks = 0;
  int errors = 0;

  mips_mc_controller #(.EN_ADDI(1'b1), .EN_JUMP(1'b1), .ALUCTL_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .i_or_d(i_or_d), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ir_write(ir_write), .mem_write(mem_write),
    .mem_req(mem_req), .pc_en(pc_en), .reg_write(reg_write),
    .alu_control(alu_control), .illegal(illegal), .state_dbg(state_dbg)
  );

  mips_mc_controller #(.EN_ADDI(1'b1), .EN_JUMP(1'b0), .ALUCTL_W(3)) dut_nj (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_to_reg(mem_to_reg2), .reg_dst(reg_dst2),
    .i_or_d(i_or_d2), .pc_src(pc_src2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .ir_write(ir_write2), .mem_write(mem_write2),
    .mem_req(mem_req2), .pc_en(pc_en2), .reg_write(reg_write2),
    .alu_control(alu_control2), .illegal(illegal2), .state_dbg(state_dbg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance to the next low phase, apply handshake inputs, let outputs settle.
  task automatic next_cycle(input logic mr, input logic z);
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b100011; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_state",   state_dbg, 4'd0);
    chk("rst_mem_req", mem_req, 1'b1);
    chk("rst_srcb",    alu_src_b, 2'b01);
    chk("rst_irw",     ir_write, 1'b0);
    chk("rst_regw",    reg_write, 1'b0);
    chk("rst_aluctl",  alu_control, 4'h2);

    // FETCH waits while memory is not ready
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fetch_wait_irw", ir_write, 1'b0);
    chk("fetch_wait_pc",  pc_en, 1'b0);

    // lw: 0,1,2,3,4,0
    next_cycle(1'b1, 1'b0);
    chk("lw_s0",      state_dbg, 4'd0);
    chk("lw_f_irw",   ir_write, 1'b1);
    chk("lw_f_pcen",  pc_en, 1'b1);
    chk("lw_f_iord",  i_or_d, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("lw_s1",      state_dbg, 4'd1);
    chk("lw_d_srcb",  alu_src_b, 2'b11);
    next_cycle(1'b1, 1'b0);
    chk("lw_s2",      state_dbg, 4'd2);
    chk("lw_a_srca",  alu_src_a, 1'b1);
    chk("lw_a_srcb",  alu_src_b, 2'b10);
    chk("lw_a_regw",  reg_write, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("lw_s3",      state_dbg, 4'd3);
    chk("lw_r_req",   mem_req, 1'b1);
    chk("lw_r_iord",  i_or_d, 1'b1);
    chk("lw_r_regw",  reg_write, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("lw_s4",      state_dbg, 4'd4);
    chk("lw_wb_regw", reg_write, 1'b1);
    chk("lw_wb_m2r",  mem_to_reg, 1'b1);
    chk("lw_wb_dst",  reg_dst, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("lw_end",     state_dbg, 4'd0);
    chk("lw_end_regw", reg_write, 1'b0);
    opcode = 6'b101011;

    // sw with two wait cycles in MEMWRITE
    next_cycle(1'b1, 1'b0);
    chk("sw_s1", state_dbg, 4'd1);
    next_cycle(1'b1, 1'b0);
    chk("sw_s2", state_dbg, 4'd2);
    chk("sw_s2_mw", mem_write, 1'b0);
    next_cycle(1'b0, 1'b0);
    chk("sw_wait1", state_dbg, 4'd5);
    chk("sw_wait1_mw", mem_write, 1'b0);
    chk("sw_wait1_req", mem_req, 1'b1);
    next_cycle(1'b0, 1'b0);
    chk("sw_wait2", state_dbg, 4'd5);
    chk("sw_wait2_mw", mem_write, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("sw_go", state_dbg, 4'd5);
    chk("sw_go_mw", mem_write, 1'b1);
    chk("sw_go_iord", i_or_d, 1'b1);
    next_cycle(1'b1, 1'b0);
    chk("sw_end", state_dbg, 4'd0);
    chk("sw_end_mw", mem_write, 1'b0);
    opcode = 6'b000100;

    // beq taken
    next_cycle(1'b1, 1'b0);
    chk("beq1_s1", state_dbg, 4'd1);
    next_cycle(1'b1, 1'b1);
    chk("beq1_s8", state_dbg, 4'd8);
    chk("beq1_pcen", pc_en, 1'b1);
    chk("beq1_pcsrc", pc_src, 2'b01);
    chk("beq1_aluctl", alu_control, 4'h6);
    next_cycle(1'b1, 1'b0);
    chk("beq1_end", state_dbg, 4'd0);
    // beq not taken
    next_cycle(1'b1, 1'b0);
    chk("beq0_s1", state_dbg, 4'd1);
    next_cycle(1'b1, 1'b0);
    chk("beq0_s8", state_dbg, 4'd8);
    chk("beq0_pcen", pc_en, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("beq0_end", state_dbg, 4'd0);
    opcode = 6'b000000; funct = 6'b101010;

    // R-type slt
    next_cycle(1'b1, 1'b0);
    chk("slt_s1", state_dbg, 4'd1);
    next_cycle(1'b1, 1'b0);
    chk("slt_s6", state_dbg, 4'd6);
    chk("slt_aluctl", alu_control, 4'h7);
    chk("slt_srca", alu_src_a, 1'b1);
    chk("slt_srcb", alu_src_b, 2'b00);
    next_cycle(1'b1, 1'b0);
    chk("slt_s7", state_dbg, 4'd7);
    chk("slt_dst", reg_dst, 1'b1);
    chk("slt_regw", reg_write, 1'b1);
    chk("slt_ill", illegal, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("slt_end", state_dbg, 4'd0);
    funct = 6'b111111;

    // R-type with undefined funct
    next_cycle(1'b1, 1'b0);
    chk("badfn_s1", state_dbg, 4'd1);
    next_cycle(1'b1, 1'b0);
    chk("badfn_s6", state_dbg, 4'd6);
    chk("badfn_s6_ill", illegal, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("badfn_s7", state_dbg, 4'd7);
    chk("badfn_ill", illegal, 1'b1);
    chk("badfn_regw", reg_write, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("badfn_end", state_dbg, 4'd0);
    chk("badfn_end_ill", illegal, 1'b0);
    opcode = 6'b001000;

    // addi
    next_cycle(1'b1, 1'b0);
    chk("addi_s1", state_dbg, 4'd1);
    next_cycle(1'b1, 1'b0);
    chk("addi_s9", state_dbg, 4'd9);
    chk("addi_srcb", alu_src_b, 2'b10);
    chk("addi_aluctl", alu_control, 4'h2);
    next_cycle(1'b1, 1'b0);
    chk("addi_s10", state_dbg, 4'd10);
    chk("addi_regw", reg_write, 1'b1);
    chk("addi_dst", reg_dst, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("addi_end", state_dbg, 4'd0);
    opcode = 6'b000010;

    // j: supported on dut, trapped on dut_nj
    next_cycle(1'b1, 1'b0);
    chk("j_s1", state_dbg, 4'd1);
    chk("j_ill", illegal, 1'b0);
    chk("nj_s1", state_dbg2, 4'd1);
    chk("nj_ill", illegal2, 1'b1);
    next_cycle(1'b1, 1'b0);
    chk("j_s11", state_dbg, 4'd11);
    chk("j_pcsrc", pc_src, 2'b10);
    chk("j_pcen", pc_en, 1'b1);
    chk("nj_back", state_dbg2, 4'd0);
    chk("nj_ill_off", illegal2, 1'b0);
    next_cycle(1'b1, 1'b0);
    chk("j_end", state_dbg, 4'd0);
    opcode = 6'b111111;

    // undefined opcode
    next_cycle(1'b1, 1'b0);
    chk("badop_s1", state_dbg, 4'd1);
    chk("badop_ill", illegal, 1'b1);
    next_cycle(1'b1, 1'b0);
    chk("badop_back", state_dbg, 4'd0);
    chk("badop_ill_off", illegal, 1'b0);
    opcode = 6'b101011;

    // reset while waiting in MEMWRITE
    next_cycle(1'b1, 1'b0);
    chk("rsw_s1", state_dbg, 4'd1);
    next_cycle(1'b1, 1'b0);
    chk("rsw_s2", state_dbg, 4'd2);
    next_cycle(1'b0, 1'b0);
    chk("rsw_s5", state_dbg, 4'd5);
    chk("rsw_s5_mw", mem_write, 1'b0);
    reset = 1'b1;
    #1;
    chk("rsw_async", state_dbg, 4'd0);
    chk("rsw_async_mw", mem_write, 1'b0);
    chk("rsw_async_req", mem_req, 1'b1);
    next_cycle(1'b1, 1'b0);
    chk("rsw_held", state_dbg, 4'd0);
    chk("rsw_held_mw", mem_write, 1'b0);
    reset = 1'b0;
    #1;
    chk("rsw_fetch_irw", ir_write, 1'b1);
    next_cycle(1'b1, 1'b0);
    chk("rsw_restart", state_dbg, 4'd1);
    chk("rsw_restart_mw", mem_write, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
